// File: rtl/aes_encipher_ctrl.sv
// -----------------------------------------------------------------------------
// aes_encipher_ctrl
//
// Sequencing controller for the AES encipher round datapath.
//
// It runs one initial AddRoundKey round and then Nr rounds. Each round
// steps the shared 32-bit S-box over the four state words and then commits
// a MAIN or FINAL round into the block register. Every output is registered
// (Moore style), so each output shows the value for the state being entered.
//
// Ports:
//   clk            in   system clock; all logic on the rising edge
//   reset          in   synchronous, active-high reset
//   next           in   start request; sampled only while idle
//   keylen         in   0 = AES-128, 1 = AES-256; latched at start
//   key_ready      in   key expansion complete; a start needs this high
//   ready          out  idle and able to accept next
//   round_type     out  0 = INIT, 1 = MAIN, 2 = FINAL (datapath round mux)
//   round_key_addr out  current round number (round-key store address)
//   sbox_mux_ctrl  out  state word 0..3 routed to the shared S-box
//   sword_we       out  write the S-box result into the selected state word
//   block_we       out  write the full round result into the block register
// -----------------------------------------------------------------------------
module aes_encipher_ctrl #(
  parameter int AES128_ROUNDS = 10,
  parameter int AES256_ROUNDS = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next,
  input  logic       keylen,
  input  logic       key_ready,
  output logic       ready,
  output logic [1:0] round_type,
  output logic [3:0] round_key_addr,
  output logic [1:0] sbox_mux_ctrl,
  output logic       sword_we,
  output logic       block_we
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_SBOX  = 2'd2,
    ST_ROUND = 2'd3
  } state_t;

  localparam logic [1:0] RT_INIT  = 2'd0;
  localparam logic [1:0] RT_MAIN  = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;

  // Number of rounds for the selected key length.
  function automatic logic [3:0] num_rounds(input logic kl);
    if (kl) begin
      return 4'(AES256_ROUNDS);
    end else begin
      return 4'(AES128_ROUNDS);
    end
  endfunction

  state_t     state_r,     state_s;
  logic [3:0] round_r,     round_s;
  logic [1:0] sword_ctr_r, sword_ctr_s;
  logic       keylen_r,    keylen_s;

  logic       ready_s;
  logic [1:0] round_type_s;
  logic [3:0] round_key_addr_s;
  logic [1:0] sbox_mux_ctrl_s;
  logic       sword_we_s;
  logic       block_we_s;
  logic [3:0] nr_s;

  // Next-state logic, plus the output values for the state being entered.
  always_comb begin
    state_s          = state_r;
    round_s          = round_r;
    sword_ctr_s      = sword_ctr_r;
    keylen_s         = keylen_r;
    ready_s          = 1'b1;
    round_type_s     = RT_INIT;
    round_key_addr_s = 4'd0;
    sbox_mux_ctrl_s  = 2'd0;
    sword_we_s       = 1'b0;
    block_we_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (next && key_ready) begin
          keylen_s = keylen;
          round_s  = 4'd0;
          state_s  = ST_INIT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_INIT: begin
        round_s     = 4'd1;
        sword_ctr_s = 2'd0;
        state_s     = ST_SBOX;
      end
      ST_SBOX: begin
        // The counter parks at 3 here; ROUND restarts it for the next round.
        if (sword_ctr_r == 2'd3) begin
          state_s     = ST_ROUND;
        end else begin
          sword_ctr_s = sword_ctr_r + 2'd1;
        end
      end
      ST_ROUND: begin
        if (round_r == num_rounds(keylen_r)) begin
          state_s     = ST_IDLE;
        end else begin
          round_s     = round_r + 4'd1;
          sword_ctr_s = 2'd0;
          state_s     = ST_SBOX;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        round_s     = 4'd0;
        sword_ctr_s = 2'd0;
        keylen_s    = 1'b0;
      end
    endcase

    // Moore outputs decoded from the next state, so they register in step
    // with the state itself.
    nr_s = num_rounds(keylen_s);
    case (state_s)
      ST_IDLE: begin
        ready_s = 1'b1;
      end
      ST_INIT: begin
        ready_s    = 1'b0;
        block_we_s = 1'b1;
      end
      ST_SBOX: begin
        ready_s          = 1'b0;
        sword_we_s       = 1'b1;
        sbox_mux_ctrl_s  = sword_ctr_s;
        round_key_addr_s = round_s;
        round_type_s     = (round_s == nr_s) ? RT_FINAL : RT_MAIN;
      end
      ST_ROUND: begin
        ready_s          = 1'b0;
        block_we_s       = 1'b1;
        sbox_mux_ctrl_s  = sword_ctr_s;
        round_key_addr_s = round_s;
        round_type_s     = (round_s == nr_s) ? RT_FINAL : RT_MAIN;
      end
      default: begin
        ready_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      round_r        <= 4'd0;
      sword_ctr_r    <= 2'd0;
      keylen_r       <= 1'b0;
      ready          <= 1'b1;
      round_type     <= RT_INIT;
      round_key_addr <= 4'd0;
      sbox_mux_ctrl  <= 2'd0;
      sword_we       <= 1'b0;
      block_we       <= 1'b0;
    end else begin
      state_r        <= state_s;
      round_r        <= round_s;
      sword_ctr_r    <= sword_ctr_s;
      keylen_r       <= keylen_s;
      ready          <= ready_s;
      round_type     <= round_type_s;
      round_key_addr <= round_key_addr_s;
      sbox_mux_ctrl  <= sbox_mux_ctrl_s;
      sword_we       <= sword_we_s;
      block_we       <= block_we_s;
    end
  end

endmodule

// File: doc/aes_encipher_ctrl.md
Name: aes_encipher_ctrl

Overview:
Sequencing controller for the AES encipher round datapath. It runs the round schedule: an initial AddRoundKey round, then Nr rounds. Each round time-multiplexes one shared 32-bit S-box over the four state words, then commits a MAIN or FINAL round. It drives round type, round-key address, S-box word select and block write enables, and exposes a next/ready handshake to the core.

Parameters:
AES128_ROUNDS, 10, Nr used when keylen=0
AES256_ROUNDS, 14, Nr used when keylen=1

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
next  input  1  start request; sampled only in IDLE
keylen  input  1  0 = AES-128, 1 = AES-256; latched at start
key_ready  input  1  key expansion complete; start is gated by it
ready  output  1  high when idle and able to accept next
round_type  output  2  0 = INIT, 1 = MAIN, 2 = FINAL; drives datapath round mux
round_key_addr  output  4  current round number; addresses round-key store
sbox_mux_ctrl  output  2  selects state word 0..3 for the shared S-box
sword_we  output  1  write S-box result into the selected state word
block_we  output  1  write the full round result into the block register

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). No asynchronous paths.
- Reset values: state=IDLE, ready=1, round_type=0, round_key_addr=0, sbox_mux_ctrl=0, sword_we=0, block_we=0. Internal counters and latched keylen clear to 0.
- All outputs are registered (Moore). sword_we and block_we are never high in the same cycle.
- States: IDLE, INIT, SBOX, ROUND.
- IDLE:
  - ready=1, write enables 0.
  - On next=1 and key_ready=1: latch keylen, set round=0, go to INIT. ready falls on the following cycle.
  - If next=1 with key_ready=0: request is ignored, not queued.
- INIT (1 cycle): round_type=INIT, round_key_addr=0, block_we=1. Then set round=1, sword_ctr=0, go to SBOX.
- SBOX (4 cycles): sbox_mux_ctrl=sword_ctr (0,1,2,3), sword_we=1, round_key_addr=round. round_type=FINAL if round==Nr, else MAIN. After sword_ctr==3, go to ROUND.
- ROUND (1 cycle): block_we=1, round_key_addr=round, round_type as in SBOX.
  - If round==Nr: go to IDLE; ready=1 the next cycle.
  - Else: round+1, sword_ctr=0, go to SBOX.
- Latency:
  - ready is low for exactly 1+5*Nr cycles: 51 for AES-128, 71 for AES-256.
  - ready rises the cycle after the FINAL block_we.
- Nr is taken from the latched keylen; changes to keylen mid-operation have no effect.
- next while busy (ready=0) is ignored. next held high continuously restarts immediately once IDLE is reached and key_ready=1.
- key_ready falling mid-operation is ignored; the current block completes.
- reset asserted in any state: all state and outputs return to reset values on the next edge. No partial writes are issued in that cycle.
- round is 4-bit and wrap is impossible: it is bounded by Nr ≤ 14. sword_ctr is 2-bit and wraps 3→0 only on the ROUND transition.
- Any unreachable state encoding returns to IDLE with reset outputs.

Test Plan:
- Reset: assert reset for 2 cycles mid-operation -> ready=1, round_type=0, round_key_addr=0, sword_we=0, block_we=0 on the next edge.
- AES-128: keylen=0, key_ready=1, one-cycle next pulse -> ready low for 51 cycles.
  - round_key_addr sequence across block_we pulses is 0,1..10.
  - 11 block_we pulses and 40 sword_we pulses in total.
  - Last block_we carries round_type=2.
- AES-256: keylen=1, next pulse -> ready low for 71 cycles.
  - Final round_key_addr=14 with round_type=2.
  - 15 block_we pulses and 56 sword_we pulses in total.
- S-box cadence: within each round, sbox_mux_ctrl=0,1,2,3 on consecutive sword_we cycles, immediately followed by one block_we cycle.
- Handshake gating:
  - next with key_ready=0 -> no state change, ready stays 1.
  - next pulsed at cycle 10 of a busy operation -> ignored, total latency is still 51.
  - next held high -> second operation starts with INIT one cycle after ready rises.
- keylen toggled from 0 to 1 at cycle 5 of an AES-128 run -> run still ends at round_key_addr=10, 51 cycles.
